// File: rtl/player2_sprite_renderer_pkg.sv
// Shared sprite constants and types for the player sprite renderers.
package sprite_pkg;

   localparam int unsigned SPR_W   = 16;
   localparam int unsigned SPR_H   = 16;
   localparam int unsigned COORD_W = 10;
   localparam int unsigned OFF_W   = 11;
   localparam int unsigned ADDR_W  = 19;
   localparam int unsigned RGB_W   = 24;

   typedef logic [RGB_W-1:0]   rgb_t;
   typedef logic [COORD_W-1:0] coord_t;

   localparam rgb_t TRANSPARENT = 24'h000000;

   typedef struct packed {
      coord_t x;
      coord_t y;
      logic   face;
   } sprite_pos_t;

endpackage

// File: rtl/player2_sprite_renderer_if.sv
// Scan, position-update, ROM and composited-pixel signals of the sprite renderer.
interface player2_sprite_renderer_if;
   import sprite_pkg::*;

   coord_t              DrawX;
   coord_t              DrawY;
   logic                pix_valid;
   rgb_t                bg_color;
   logic                frame_start;
   coord_t              pos_x;
   coord_t              pos_y;
   logic                pos_wr;
   logic                face_left;
   logic [ADDR_W-1:0]   read_address;
   rgb_t                rom_data;
   rgb_t                pixel_out;
   logic                sprite_hit;
   logic                out_valid;

   modport master (
      output DrawX, DrawY, pix_valid, bg_color, frame_start,
      output pos_x, pos_y, pos_wr, face_left, rom_data,
      input  read_address, pixel_out, sprite_hit, out_valid
   );

   modport slave (
      input  DrawX, DrawY, pix_valid, bg_color, frame_start,
      input  pos_x, pos_y, pos_wr, face_left, rom_data,
      output read_address, pixel_out, sprite_hit, out_valid
   );

endinterface

// File: rtl/player2_sprite_renderer_sprite_pos_buffer.sv
// Double-buffered sprite position: writes land in a shadow set and move to
// the active set on frame_start, so a frame never sees a half-applied move.
module sprite_pos_buffer
   import sprite_pkg::*;
#(
   parameter coord_t INIT_X = 10'd480,
   parameter coord_t INIT_Y = 10'd400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        pos_wr,
   input  sprite_pos_t new_pos,
   output sprite_pos_t active
);

   localparam sprite_pos_t INIT_POS = '{x: INIT_X, y: INIT_Y, face: 1'b0};

   sprite_pos_t shadow;
   logic        pend;

   // A write coinciding with frame_start bypasses the shadow wait.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= INIT_POS;
         active <= INIT_POS;
         pend   <= 1'b0;
      end else if (pos_wr && frame_start) begin
         shadow <= new_pos;
         active <= new_pos;
         pend   <= 1'b0;
      end else if (pos_wr) begin
         shadow <= new_pos;
         pend   <= 1'b1;
      end else if (frame_start && pend) begin
         active <= shadow;
         pend   <= 1'b0;
      end
   end

endmodule

// File: rtl/player2_sprite_renderer.sv
// Player 2 sprite compositor: hit test, ROM addressing and 3-stage pixel
// pipeline overlaying the sprite on the background with black as transparent.
module player2_sprite_renderer
   import sprite_pkg::*;
#(
   parameter coord_t INIT_X = 10'd480,
   parameter coord_t INIT_Y = 10'd400
) (
   input  logic                     Clk,
   input  logic                     Reset,
   player2_sprite_renderer_if.slave bus
);

   sprite_pos_t       req_pos;
   sprite_pos_t       act_pos;
   logic [OFF_W-1:0]  dx;
   logic [OFF_W-1:0]  dy;
   logic [OFF_W-1:0]  col;
   logic              in_box;
   logic [ADDR_W-1:0] addr_c;
   logic              opaque;

   logic              hit1;
   logic              v1;
   rgb_t              bg1;
   logic              hit2;
   logic              v2;
   rgb_t              bg2;

   assign req_pos = '{x: bus.pos_x, y: bus.pos_y, face: bus.face_left};

   sprite_pos_buffer #(
      .INIT_X (INIT_X),
      .INIT_Y (INIT_Y)
   ) u_pos (
      .clk         (Clk),
      .reset       (Reset),
      .frame_start (bus.frame_start),
      .pos_wr      (bus.pos_wr),
      .new_pos     (req_pos),
      .active      (act_pos)
   );

   // Negative offsets become large unsigned values and fail the box test.
   always_comb begin
      dx     = {1'b0, bus.DrawX} - {1'b0, act_pos.x};
      dy     = {1'b0, bus.DrawY} - {1'b0, act_pos.y};
      in_box = (dx < OFF_W'(SPR_W)) && (dy < OFF_W'(SPR_H)) && bus.pix_valid;
      col    = act_pos.face ? (OFF_W'(SPR_W - 1) - dx) : dx;
      addr_c = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(col);
   end

   assign opaque = hit2 && (bus.rom_data != TRANSPARENT);

   // Stage 1 issues the ROM read, stage 2 waits on the ROM, stage 3 composites.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.read_address <= '0;
         hit1             <= 1'b0;
         v1               <= 1'b0;
         bg1              <= '0;
         hit2             <= 1'b0;
         v2               <= 1'b0;
         bg2              <= '0;
         bus.pixel_out    <= '0;
         bus.sprite_hit   <= 1'b0;
         bus.out_valid    <= 1'b0;
      end else begin
         bus.read_address <= in_box ? addr_c : '0;
         hit1             <= in_box;
         v1               <= bus.pix_valid;
         bg1              <= bus.bg_color;
         hit2             <= hit1;
         v2               <= v1;
         bg2              <= bg1;
         bus.out_valid    <= v2;
         if (v2) begin
            bus.pixel_out  <= opaque ? bus.rom_data : bg2;
            bus.sprite_hit <= opaque;
         end else begin
            bus.pixel_out  <= '0;
            bus.sprite_hit <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_player2_sprite_renderer.sv
// Directed and random scan of the Player 2 renderer against a coordinate-level model.
module tb_player2_sprite_renderer;
   import sprite_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   player2_sprite_renderer_if bus ();

   player2_sprite_renderer dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   rgb_t rom [256];

   // Sprite ROM with one cycle of read latency.
   always @(posedge clk)
      bus.rom_data <= (bus.read_address < 19'd256) ? rom[bus.read_address[7:0]] : 24'h000000;

   typedef struct {
      int   addr;
      logic shit;
      rgb_t pix;
      logic v;
   } exp_t;

   exp_t q[$];
   int   m_ax, m_ay, m_sx, m_sy;
   logic m_af, m_sf, m_pend;
   int   compared   = 0;
   int   mismatched = 0;
   int   w          = int'(SPR_W);
   int   h          = int'(SPR_H);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_bubble();
      exp_t b;
      b.addr = 0; b.shit = 1'b0; b.pix = 24'h0; b.v = 1'b0;
      q.push_back(b);
   endtask

   task automatic model_reset();
      m_ax = 480; m_ay = 400; m_af = 1'b0;
      m_sx = 480; m_sy = 400; m_sf = 1'b0;
      m_pend = 1'b0;
      q.delete();
      push_bubble();
      push_bubble();
   endtask

   // One pixel clock: drive, predict, clock, then check address and the pixel from 3 clocks back.
   task automatic step(input int x, input int y, input logic v, input rgb_t bg,
                       input logic fs, input logic wr, input int px, input int py, input logic pf);
      exp_t e;
      int   dx, dy, col;
      rgb_t tex;
      @(negedge clk);
      rst             = 1'b0;
      bus.DrawX       = 10'(x);
      bus.DrawY       = 10'(y);
      bus.pix_valid   = v;
      bus.bg_color    = bg;
      bus.frame_start = fs;
      bus.pos_wr      = wr;
      bus.pos_x       = 10'(px);
      bus.pos_y       = 10'(py);
      bus.face_left   = pf;
      dx  = x - m_ax;
      dy  = y - m_ay;
      e.v = v;
      if (v && dx >= 0 && dx < w && dy >= 0 && dy < h) begin
         col    = m_af ? (w - 1 - dx) : dx;
         e.addr = dy * w + col;
         tex    = rom[e.addr];
      end else begin
         e.addr = 0;
         tex    = TRANSPARENT;
      end
      if (!v) begin
         e.pix = 24'h0; e.shit = 1'b0;
      end else if (tex != TRANSPARENT) begin
         e.pix = tex;   e.shit = 1'b1;
      end else begin
         e.pix = bg;    e.shit = 1'b0;
      end
      q.push_back(e);
      @(posedge clk);
      if (wr && fs) begin
         m_ax = px; m_ay = py; m_af = pf; m_pend = 1'b0;
      end else if (wr) begin
         m_sx = px; m_sy = py; m_sf = pf; m_pend = 1'b1;
      end else if (fs && m_pend) begin
         m_ax = m_sx; m_ay = m_sy; m_af = m_sf; m_pend = 1'b0;
      end
      #1;
      chk("read_address", 32'(bus.read_address), 32'(e.addr));
      if (q.size() == 3) begin
         e = q.pop_front();
         chk("pixel_out",  32'(bus.pixel_out),  32'(e.pix));
         chk("sprite_hit", 32'(bus.sprite_hit), 32'(e.shit));
         chk("out_valid",  32'(bus.out_valid),  32'(e.v));
      end
   endtask

   // Reset for one clock while a hitting pixel is presented; everything must read zero after.
   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b1;
      bus.DrawX       = 10'd480;
      bus.DrawY       = 10'd400;
      bus.pix_valid   = 1'b1;
      bus.bg_color    = 24'h203040;
      bus.frame_start = 1'b0;
      bus.pos_wr      = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_read_address", 32'(bus.read_address), 32'd0);
      chk("rst_pixel_out",    32'(bus.pixel_out),    32'd0);
      chk("rst_sprite_hit",   32'(bus.sprite_hit),   32'd0);
      chk("rst_out_valid",    32'(bus.out_valid),    32'd0);
      model_reset();
   endtask

   initial begin
      logic [31:0] r;
      int          x, y;
      for (int i = 0; i < 256; i++) begin
         r = $urandom;
         rom[i] = (r[1:0] == 2'b00) ? 24'h000000 : (24'(r >> 2) | 24'h000001);
      end
      rom[0]   = 24'hFFFFFF;
      rom[87]  = 24'h000000;
      rom[15]  = 24'h11AA22;
      rom[153] = 24'h00FF00;

      bus.DrawX = '0; bus.DrawY = '0; bus.pix_valid = 1'b0; bus.bg_color = '0;
      bus.frame_start = 1'b0; bus.pos_x = '0; bus.pos_y = '0;
      bus.pos_wr = 1'b0; bus.face_left = 1'b0;

      do_reset();

      // Top-left texel, then a transparent texel inside the box.
      step(480, 400, 1'b1, 24'h203040, 1'b0, 1'b0, 0, 0, 1'b0);
      step(487, 405, 1'b1, 24'h203040, 1'b0, 1'b0, 0, 0, 1'b0);

      // Mirror through a simultaneous write and frame_start.
      step(0, 0, 1'b0, 24'h0, 1'b1, 1'b1, 480, 400, 1'b1);
      step(480, 400, 1'b1, 24'h556677, 1'b0, 1'b0, 0, 0, 1'b0);
      step(495, 400, 1'b1, 24'h556677, 1'b0, 1'b0, 0, 0, 1'b0);

      // Mid-frame write stays in the shadow set until frame_start.
      step(0, 0, 1'b0, 24'h0, 1'b0, 1'b1, 100, 50, 1'b0);
      step(100, 50, 1'b1, 24'h0A0B0C, 1'b0, 1'b0, 0, 0, 1'b0);
      step(480, 400, 1'b1, 24'h0A0B0C, 1'b0, 1'b0, 0, 0, 1'b0);
      step(0, 0, 1'b0, 24'h0, 1'b1, 1'b0, 0, 0, 1'b0);
      step(100, 50, 1'b1, 24'h0A0B0C, 1'b0, 1'b0, 0, 0, 1'b0);
      step(480, 400, 1'b1, 24'h0A0B0C, 1'b0, 1'b0, 0, 0, 1'b0);

      // Clipping at the bottom-right corner, no wrap to column 0.
      step(0, 0, 1'b0, 24'h0, 1'b1, 1'b1, 630, 470, 1'b0);
      step(639, 479, 1'b1, 24'h102030, 1'b0, 1'b0, 0, 0, 1'b0);
      step(0, 470, 1'b1, 24'h102030, 1'b0, 1'b0, 0, 0, 1'b0);
      step(630, 470, 1'b1, 24'h102030, 1'b0, 1'b0, 0, 0, 1'b0);
      step(631, 470, 1'b1, 24'h102030, 1'b0, 1'b0, 0, 0, 1'b0);

      // Reset while hits are in flight, then the initial position must hit again.
      do_reset();
      step(480, 400, 1'b1, 24'h203040, 1'b0, 1'b0, 0, 0, 1'b0);
      step(481, 401, 1'b1, 24'h203040, 1'b0, 1'b0, 0, 0, 1'b0);
      step(0, 0, 1'b0, 24'h0, 1'b0, 1'b0, 0, 0, 1'b0);
      step(0, 0, 1'b0, 24'h0, 1'b0, 1'b0, 0, 0, 1'b0);

      // Random scan near the sprite with occasional moves, frames and resets.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(99) < 2) begin
            do_reset();
         end else begin
            x = (m_ax + int'($urandom_range(40)) - 12) & 1023;
            y = (m_ay + int'($urandom_range(40)) - 12) & 1023;
            step(x, y, ($urandom_range(9) != 0), rgb_t'($urandom),
                 ($urandom_range(19) == 0), ($urandom_range(9) == 0),
                 int'($urandom_range(1023)), int'($urandom_range(1023)),
                 1'($urandom_range(1)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/player2_sprite_renderer.md
Name: player2_sprite_renderer

Overview:
- Per-pixel compositor for the Player 2 sprite, sitting between the VGA scan counters and the colour mux.
- Takes the current scan coordinate and the Player 2 position, and drives the read address of the Player 2 sprite ROM.
- Consumes the ROM's registered 24-bit colour and emits a composited pixel: sprite over the background, with black treated as transparent.
- Position updates are double-buffered so the sprite never tears mid-frame.

Parameters:
- SPR_W, 16, sprite width in pixels (power of two).
- SPR_H, 16, sprite height in pixels; the ROM holds SPR_W*SPR_H entries, row-major.
- INIT_X, 10'd480, Player 2 X after reset (top-left corner).
- INIT_Y, 10'd400, Player 2 Y after reset.
- TRANSPARENT, 24'h000000, ROM colour treated as see-through.

Ports:
- Clk  in  1  system clock (pixel clock domain).
- Reset  in  1  synchronous, active-high.
- DrawX  in  10  current scan column.
- DrawY  in  10  current scan row.
- pix_valid  in  1  DrawX/DrawY are in the active area this cycle.
- bg_color  in  24  background colour for this pixel.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- pos_x  in  10  requested Player 2 X.
- pos_y  in  10  requested Player 2 Y.
- pos_wr  in  1  pos_x/pos_y/face_left valid; capture into the shadow registers.
- face_left  in  1  mirror the sprite horizontally.
- read_address  out  19  address to the sprite ROM (registered).
- rom_data  in  24  ROM output; valid 1 cycle after read_address.
- pixel_out  out  24  composited colour.
- sprite_hit  out  1  pixel_out came from an opaque sprite texel.
- out_valid  out  1  pix_valid delayed to align with pixel_out.

Behaviour:
- Registers:
  - Shadow set: sx, sy, sface.
  - Active set: ax, ay, aface.
  - pend flag.
- pos_wr: load the shadow set and set pend.
- frame_start with pend=1: copy shadow to active and clear pend.
- pos_wr and frame_start in the same cycle: the new pos_x/pos_y/face_left go straight to the active set and pend stays 0.
- frame_start with pend=0: active set unchanged.
- Hit test (combinational, stage 0):
  - dx = DrawX - ax and dy = DrawY - ay, as 11-bit two's-complement.
  - in_box = (dx < SPR_W) && (dy < SPR_H) && pix_valid, using unsigned compare on the 11-bit values, so negative offsets fail.
  - Sprites partly off the right or bottom edge clip naturally; no wrap-around to column 0.
- Column: col = aface ? SPR_W-1-dx : dx.
- Address: row*SPR_W + col, zero-extended to 19 bits.
- Pipeline, with latency 3 from DrawX to pixel_out:
  - Stage 1 (registered): read_address, hit1 = in_box, bg1, v1. When in_box=0, read_address = 0.
  - Stage 2: the ROM registers rom_data. This block registers hit2, bg2, v2.
  - Stage 3 (registered):
    - opaque = hit2 && (rom_data != TRANSPARENT).
    - pixel_out = opaque ? rom_data : bg2.
    - sprite_hit = opaque; out_valid = v2.
    - When v2=0: pixel_out = 24'h000000 and sprite_hit = 0.
- Reset: ax/sx = INIT_X, ay/sy = INIT_Y, aface/sface = 0, pend = 0. read_address, pixel_out, sprite_hit, out_valid and all pipeline flags = 0.
- Reset mid-frame: the pipeline flushes within one cycle, and no stale hit is emitted after Reset deasserts.
- Active-set updates take effect on the pixel entering stage 0 in the cycle after frame_start. Pixels already in flight keep their old hit result.
- No backpressure: one pixel per clock in, one out.

Decomposition:
- Package sprite_pkg:
  - SPR_W, SPR_H, the TRANSPARENT constant.
  - Typedef rgb_t (24-bit).
  - Typedef coord_t (10-bit).
  - Typedef sprite_pos_t struct {x, y, face}.
- Sub-module sprite_pos_buffer: shadow/active/pend logic, reused for Player 1.
- The pipeline stays in the top module.
- The ROM is instantiated by the parent, not here.

Test Plan:
- Reset then scan (480,400), pix_valid=1, ROM model returns 24'hFFFFFF, bg=24'h203040 -> 3 cycles later pixel_out=FFFFFF, sprite_hit=1, out_valid=1; read_address=0 one cycle after input.
- Scan (487,405), ROM returns 000000 -> read_address=5*16+7=87; pixel_out=bg (203040), sprite_hit=0.
- face_left=1 via pos_wr+frame_start; scan (480,400) -> read_address=15; scan (495,400) -> read_address=0.
- pos_wr to (100,50) mid-frame, no frame_start; scan (100,50) -> no hit, (480,400) still hits. After a frame_start pulse, (100,50) hits and (480,400) misses.
- Position (630,470), scan (639,479) -> hit at address 9*16+9=153. Scan (0,470) -> no hit (no wrap).
- Stream hitting pixels, assert Reset for 1 cycle -> the next cycle sprite_hit=0, out_valid=0, pixel_out=0. Position returns to (480,400).
